pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter N, default 64, data width in bits (N >= 1).
REQ-002 SHALL have parameter RST_VAL, default 0, N-bit value loaded into all data registers on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  discards all held entries at next edge.
REQ-006 SHALL have port in_valid  input  1  upstream data valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept in_data this cycle.
REQ-008 SHALL have port in_data  input  N  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_data  output  N  payload of oldest held entry.
REQ-012 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-013 Transfer in: in_valid & in_ready at rising edge; transfer out: out_valid & out_ready at rising edge.
REQ-014 Entries SHALL leave in arrival order; no entry duplicated or lost except by flush/reset.
REQ-015 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-016 Latency: entry accepted at edge k SHALL appear on out_valid/out_data after edge k when stage empty (one cycle).
REQ-017 With skid enabled, states EMPTY (occ 0), HALF (main reg full, occ 1), FULL (main + skid full, occ 2).
REQ-018 EMPTY: accept -> HALF; else stay.
REQ-019 HALF: accept & drain -> HALF (main reloads with in_data); accept only -> FULL (in_data into skid); drain only -> EMPTY; neither -> stay.
REQ-020 FULL: drain -> HALF (skid moves to main); no accept possible; else stay.
REQ-021 With skid enabled, in_ready SHALL be registered: in_ready = (state != FULL), no combinational path from out_ready.
REQ-022 flush=1 at an edge SHALL force EMPTY, out_valid=0, occupancy=0; flush has priority over simultaneous accept (input entry dropped, not held); data registers need not change.
REQ-023 in_ready SHALL be 1 in the cycle after a flush edge.
REQ-024 occupancy SHALL equal out_valid + skid_valid at all times.
REQ-025 in_valid=0 SHALL never modify any data register content visible on out_data.

Reset
REQ-026 rst=1 SHALL asynchronously force out_valid=0, occupancy=0, internal skid valid=0, out_data=RST_VAL, skid data=RST_VAL, state EMPTY.
REQ-027 With skid enabled, in_ready SHALL be 1 during and after reset; rst mid-transfer discards all entries.
REQ-028 First transfer in SHALL be possible at first rising edge after rst deasserts.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN SHALL select the skid buffer.
REQ-030 Defined: two-entry skid buffer per REQ-017..021; full throughput with registered in_ready.
REQ-031 Undefined: single register only, occupancy in {0,1}, in_ready = !out_valid | out_ready (combinational), FULL state absent; all other requirements unchanged.

Verification
REQ-032 Reset: rst=1 mid-stream with N=64, RST_VAL=0xDEAD -> out_valid=0, out_data=0xDEAD, occupancy=0 immediately, no clock needed.
REQ-033 Streaming: in_valid=1 every cycle, values 1..100, out_ready=1 -> out_data 1..100 in order, one per cycle, one-cycle latency, in_ready held 1.
REQ-034 Backpressure (skid): send 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB, in_ready=1 after first drain.
REQ-035 Flush: occupancy 2, flush=1 with in_valid=1 data 0xC -> next cycle occupancy 0, out_valid=0, in_ready=1, 0xC never emitted.
REQ-036 Random: random in_valid/out_ready at 50% for 10000 cycles vs. reference queue -> no loss, duplication or reorder; occupancy always matches.
REQ-037 Build without PIPE_STAGE_SKID_EN: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 same cycle, occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register stage.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid buffer
// (registered in_ready, full throughput). Without it the stage is a single
// register whose in_ready also looks at out_ready.
`timescale 1ns/1ps

module pipe_stage_reg #(
  parameter int          N       = 64,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  logic accept;
  logic drain;

`ifdef PIPE_STAGE_SKID_EN

  // EMPTY: nothing held; HALF: main register valid; FULL: main + skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic [N-1:0] main_data_reg;
  logic [N-1:0] main_data_next;
  logic [N-1:0] skid_data_reg;
  logic [N-1:0] skid_data_next;

  // in_ready depends only on the state register, so out_ready never reaches it.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_data_reg;
  assign occupancy = (state_reg == FULL) ? 2'd2 :
                     (state_reg == HALF) ? 2'd1 : 2'd0;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Next-state and data steering; flush wins over any simultaneous transfer.
  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    skid_data_next = skid_data_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_data_next = in_data;
            state_next     = HALF;
          end
        end
        HALF: begin
          if (accept && drain) begin
            main_data_next = in_data;
          end else if (accept) begin
            skid_data_next = in_data;
            state_next     = FULL;
          end else if (drain) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_data_next = skid_data_reg;
            state_next     = HALF;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= RST_VAL;
      skid_data_reg <= RST_VAL;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
    end
  end

`else

  logic         valid_reg;
  logic [N-1:0] data_reg;

  // The register can take new data whenever it is empty or being drained now.
  assign in_ready  = ~valid_reg | out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign occupancy = {1'b0, valid_reg};

  assign accept = in_valid & in_ready;
  assign drain  = valid_reg & out_ready;

  // Single holding register; flush drops both the held and the incoming entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_VAL;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks for pipe_stage_reg (both build options).
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam int          N       = 64;
  localparam logic [63:0] RST_VAL = 64'hDEAD;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.N(N), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] q[$];
  logic        exp_ready;
  logic        acc;
  logic        drn;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_data", out_data, RST_VAL);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Streaming 1..100 with downstream always ready
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_data = 64'(i);
      #1;
      check("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("stream_out_valid", 64'(out_valid), 64'd1);
      check("stream_out_data", out_data, 64'(i));
      check("stream_occupancy", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);
    check("stream_end_occ", 64'(occupancy), 64'd0);

    // Asynchronous reset mid-stream, then transfer on first edge after release
    in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b0;
    tick();
    check("pre_rst_occ", 64'(occupancy), 64'd1);
    check("pre_rst_data", out_data, 64'h55);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", out_data, RST_VAL);
    check("async_rst_occ", 64'(occupancy), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    #2;
    rst = 1'b0; in_data = 64'h77;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data", out_data, 64'h77);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("post_rst_drain_occ", 64'(occupancy), 64'd0);

    // Backpressure
    in_valid = 1'b1; in_data = 64'hA; out_ready = 1'b0;
    tick();
    check("bp_a_occ", 64'(occupancy), 64'd1);
    check("bp_a_data", out_data, 64'hA);
`ifdef PIPE_STAGE_SKID_EN
    check("bp_a_in_ready", 64'(in_ready), 64'd1);
    in_data = 64'hB;
    tick();
    check("bp_full_occ", 64'(occupancy), 64'd2);
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_full_data", out_data, 64'hA);
    in_data = 64'hEE;
    tick();
    check("bp_hold_occ", 64'(occupancy), 64'd2);
    check("bp_hold_data", out_data, 64'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_drain1_data", out_data, 64'hB);
    check("bp_drain1_occ", 64'(occupancy), 64'd1);
    check("bp_drain1_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_drain2_valid", 64'(out_valid), 64'd0);
    check("bp_drain2_occ", 64'(occupancy), 64'd0);
`else
    in_data = 64'hB;
    #1;
    check("bp_stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_hold_data", out_data, 64'hA);
    check("bp_hold_occ", 64'(occupancy), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_same_cycle_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_pass_data", out_data, 64'hB);
    check("bp_pass_occ", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drain_valid", 64'(out_valid), 64'd0);
`endif

`ifdef PIPE_STAGE_SKID_EN
    // Flush while full, with an input offered
    in_valid = 1'b1; in_data = 64'h1; out_ready = 1'b0;
    tick();
    in_data = 64'h2;
    tick();
    check("flush_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 64'hC;
    tick();
    check("flush_full_occ", 64'(occupancy), 64'd0);
    check("flush_full_valid", 64'(out_valid), 64'd0);
    check("flush_full_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("flush_full_no_c", 64'(out_valid), 64'd0);
`endif

    // Flush beats a simultaneous accept
    in_valid = 1'b1; in_data = 64'h3; out_ready = 1'b0;
    tick();
    check("flush2_pre_occ", 64'(occupancy), 64'd1);
    flush = 1'b1; in_data = 64'hC; out_ready = 1'b1;
    tick();
    check("flush2_occ", 64'(occupancy), 64'd0);
    check("flush2_valid", 64'(out_valid), 64'd0);
    check("flush2_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush2_no_c", 64'(out_valid), 64'd0);

    // Random traffic against a reference queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      #1;
`ifdef PIPE_STAGE_SKID_EN
      exp_ready = (q.size() < 2);
`else
      exp_ready = (q.size() == 0) || out_ready;
`endif
      check("rand_in_ready", 64'(in_ready), 64'(exp_ready));
      acc = in_valid & exp_ready;
      drn = (q.size() != 0) & out_ready;
      tick();
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      check("rand_occupancy", 64'(occupancy), 64'(q.size()));
      check("rand_out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) check("rand_out_data", out_data, q[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
